// File: rtl/lane_gen_pkg.sv
// Shared types and constants for the lane pattern generator.
// Imported by the interface, the PRBS lanes and the top.
package lane_gen_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ALIGN,
      DATA
   } state_t;

   typedef enum logic [1:0] {
      MODE_ZERO  = 2'd0,
      MODE_PRBS  = 2'd1,
      MODE_CNT   = 2'd2,
      MODE_FIXED = 2'd3
   } mode_t;

   localparam int PRBS_LEN    = 31;
   localparam int PRBS_TAP_HI = 30;
   localparam int PRBS_TAP_LO = 27;

   localparam logic [7:0] DEF_COMMA = 8'hBC;

endpackage

// File: rtl/lane_gen_if.sv
// Control and lane bus between the generator and its consumer.
// The generator drives lane data; the consumer drives tready.
interface lane_gen_if #(
   parameter int LANS  = 4,
   parameter int BYTES = 4
);

   logic                      en;
   logic [1:0]                mode;
   logic [7:0]                fixed_pat;
   logic                      inject_err;
   logic                      tready;
   logic [LANS*BYTES*8-1:0]   tdat;
   logic [LANS*BYTES-1:0]     tdatk;
   logic [LANS-1:0]           tdatv;
   logic [15:0]               err_cnt;

   modport master (
      input  en,
      input  mode,
      input  fixed_pat,
      input  inject_err,
      input  tready,
      output tdat,
      output tdatk,
      output tdatv,
      output err_cnt
   );

   modport slave (
      output en,
      output mode,
      output fixed_pat,
      output inject_err,
      output tready,
      input  tdat,
      input  tdatk,
      input  tdatv,
      input  err_cnt
   );

endinterface

// File: rtl/lane_prbs31.sv
// One lane of PRBS-31: o_word holds the next NBITS output bits,
// and the register advances by NBITS steps when step is high.
module lane_prbs31
   import lane_gen_pkg::*;
#(
   parameter logic [30:0] SEED  = 31'h1,
   parameter int          NBITS = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             step,
   output logic [NBITS-1:0] o_word
);

   logic [PRBS_LEN-1:0] r_s;
   logic [PRBS_LEN-1:0] w_s_nxt;

   always_comb begin
      logic [PRBS_LEN-1:0] w_s;
      logic                w_n;
      w_s     = r_s;
      w_n     = 1'b0;
      o_word  = '0;
      for (int i = 0; i < NBITS; i++) begin
         w_n       = w_s[PRBS_TAP_HI] ^ w_s[PRBS_TAP_LO];
         o_word[i] = w_n;
         w_s       = {w_s[PRBS_LEN-2:0], w_n};
      end
      w_s_nxt = w_s;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s <= SEED;
      end else if (step) begin
         r_s <= w_s_nxt;
      end
   end

endmodule

// File: rtl/lane_pattern_gen.sv
// Multi-lane stimulus source: K-comma alignment bursts followed by
// PRBS-31 / counter / fixed payload, with bit-error injection.
module lane_pattern_gen
   import lane_gen_pkg::*;
#(
   parameter int          LANS         = 4,
   parameter int          BYTES        = 4,
   parameter logic [7:0]  COMMA        = DEF_COMMA,
   parameter int          ALIGN_PERIOD = 256,
   parameter int          ALIGN_LEN    = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   lane_gen_if.master  bus
);

   localparam int LB  = BYTES * 8;
   localparam int W   = LANS * LB;
   localparam int NB  = LANS * BYTES;
   localparam int WCW = (ALIGN_PERIOD > 2) ? $clog2(ALIGN_PERIOD) : 1;

   localparam logic [WCW-1:0] ALIGN_LAST = WCW'(ALIGN_LEN - 1);
   localparam logic [WCW-1:0] FRAME_LAST = WCW'(ALIGN_PERIOD - 1);

   state_t          r_state;
   state_t          w_state_nxt;
   mode_t           r_mode;
   logic [WCW-1:0]  r_wcnt;
   logic [7:0]      r_cnt8;
   logic            r_err_pend;
   logic [15:0]     r_err_cnt;
   logic [W-1:0]    r_tdat;
   logic [NB-1:0]   r_tdatk;
   logic [LANS-1:0] r_tdatv;

   logic            w_adv;
   logic            w_start;
   logic            w_stop;
   logic            w_iss_algn;
   logic            w_iss_data;
   logic            w_wrap;
   logic            w_consume;
   logic            w_prbs_step;
   logic [W-1:0]    w_prbs;
   logic [W-1:0]    w_payload;

   assign w_adv       = !r_tdatv[0] || bus.tready;
   assign w_consume   = w_iss_data && r_err_pend;
   assign w_prbs_step = w_iss_data && (r_mode == MODE_PRBS);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_stop      = 1'b0;
      w_iss_algn  = 1'b0;
      w_iss_data  = 1'b0;
      w_wrap      = 1'b0;
      if (w_adv) begin
         unique case (r_state)
            IDLE: begin
               if (bus.en) begin
                  w_state_nxt = ALIGN;
                  w_start     = 1'b1;
               end
            end
            ALIGN: begin
               if (!bus.en) begin
                  w_state_nxt = IDLE;
                  w_stop      = 1'b1;
               end else begin
                  w_iss_algn = 1'b1;
                  if (r_wcnt == ALIGN_LAST) begin
                     w_state_nxt = DATA;
                  end
               end
            end
            DATA: begin
               // Disable takes priority over the frame wrap.
               if (!bus.en) begin
                  w_state_nxt = IDLE;
                  w_stop      = 1'b1;
               end else begin
                  w_iss_data = 1'b1;
                  if (r_wcnt == FRAME_LAST) begin
                     w_wrap      = 1'b1;
                     w_state_nxt = ALIGN;
                  end
               end
            end
            default: begin
               w_state_nxt = IDLE;
            end
         endcase
      end
   end

   genvar l;
   generate
      for (l = 0; l < LANS; l++) begin : g_lane
         lane_prbs31 #(
            .SEED  (31'(1) << l),
            .NBITS (LB)
         ) u_prbs (
            .clk    (clk),
            .rst_n  (rst_n),
            .step   (w_prbs_step),
            .o_word (w_prbs[l*LB +: LB])
         );
      end
   endgenerate

   always_comb begin
      w_payload = '0;
      unique case (r_mode)
         MODE_PRBS: begin
            w_payload = w_prbs;
         end
         MODE_CNT: begin
            for (int ln = 0; ln < LANS; ln++) begin
               for (int b = 0; b < BYTES; b++) begin
                  w_payload[(ln*BYTES+b)*8 +: 8] = r_cnt8 + 8'(b);
               end
            end
         end
         MODE_FIXED: begin
            w_payload = {NB{bus.fixed_pat}};
         end
         default: begin
            w_payload = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_mode     <= MODE_ZERO;
         r_wcnt     <= '0;
         r_cnt8     <= '0;
         r_err_pend <= 1'b0;
         r_err_cnt  <= '0;
         r_tdat     <= '0;
         r_tdatk    <= '0;
         r_tdatv    <= '0;
      end else begin
         // A pulse arriving as the pending error is spent starts a new one.
         r_err_pend <= w_consume ? bus.inject_err
                                 : (r_err_pend | bus.inject_err);
         if (w_start) begin
            r_mode <= mode_t'(bus.mode);
            r_wcnt <= '0;
         end
         if (w_stop) begin
            r_tdat  <= '0;
            r_tdatk <= '0;
            r_tdatv <= '0;
         end
         if (w_iss_algn) begin
            r_tdat  <= {NB{COMMA}};
            r_tdatk <= '1;
            r_tdatv <= '1;
            r_wcnt  <= r_wcnt + 1'b1;
         end
         if (w_iss_data) begin
            r_tdat  <= w_payload ^ W'(w_consume);
            r_tdatk <= '0;
            r_tdatv <= '1;
            if (w_wrap) begin
               r_wcnt <= '0;
               r_mode <= mode_t'(bus.mode);
            end else begin
               r_wcnt <= r_wcnt + 1'b1;
            end
            if (r_mode == MODE_CNT) begin
               r_cnt8 <= r_cnt8 + 8'(BYTES);
            end
            if (w_consume && (r_err_cnt != 16'hFFFF)) begin
               r_err_cnt <= r_err_cnt + 16'd1;
            end
         end
      end
   end

   assign bus.tdat    = r_tdat;
   assign bus.tdatk   = r_tdatk;
   assign bus.tdatv   = r_tdatv;
   assign bus.err_cnt = r_err_cnt;

endmodule

// File: tb/tb_lane_pattern_gen.sv
// Directed bench for lane_pattern_gen with hand-computed vectors.
// Inputs change and outputs are sampled 1 time unit after posedge.
module tb_lane_pattern_gen;

   logic clk = 1'b0;
   logic rst_n;

   int n_cmp = 0;
   int n_bad = 0;

   localparam logic [127:0] COMMA_W = {16{8'hBC}};
   localparam logic [127:0] PRBS_W0 =
      {32'h09000000, 32'h12000000, 32'h24000000, 32'h48000000};

   lane_gen_if #(.LANS(4), .BYTES(4)) bus ();

   lane_pattern_gen #(
      .LANS         (4),
      .BYTES        (4),
      .COMMA        (8'hBC),
      .ALIGN_PERIOD (256),
      .ALIGN_LEN    (4)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [127:0] obs,
                      input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [127:0] cw(input logic [31:0] w);
      return {4{w}};
   endfunction

   initial begin
      rst_n          = 1'b0;
      bus.en         = 1'b0;
      bus.mode       = 2'd0;
      bus.fixed_pat  = 8'h00;
      bus.inject_err = 1'b0;
      bus.tready     = 1'b1;
      cyc(2);
      chk("rst_tdatv", 128'(bus.tdatv), 128'h0);
      chk("rst_tdat", bus.tdat, 128'h0);
      chk("rst_tdatk", 128'(bus.tdatk), 128'h0);
      chk("rst_errcnt", 128'(bus.err_cnt), 128'h0);

      // counter mode, full frame
      rst_n    = 1'b1;
      bus.en   = 1'b1;
      bus.mode = 2'd2;
      cyc(1);
      chk("start_lat_tdatv", 128'(bus.tdatv), 128'h0);
      for (int k = 0; k < 4; k++) begin
         cyc(1);
         chk("align_tdat", bus.tdat, COMMA_W);
         chk("align_tdatk", 128'(bus.tdatk), 128'hFFFF);
         chk("align_tdatv", 128'(bus.tdatv), 128'hF);
      end
      cyc(1);
      chk("cnt_w5", bus.tdat, cw(32'h03020100));
      chk("cnt_w5_k", 128'(bus.tdatk), 128'h0);
      cyc(1);
      chk("cnt_w6", bus.tdat, cw(32'h07060504));
      cyc(249);
      cyc(1);
      chk("cnt_w256", bus.tdat, cw(32'hEFEEEDEC));
      cyc(1);
      chk("w257_comma", bus.tdat, COMMA_W);
      chk("w257_k", 128'(bus.tdatk), 128'hFFFF);
      cyc(3);
      cyc(1);
      chk("w261", bus.tdat, cw(32'hF3F2F1F0));

      // backpressure
      bus.tready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         cyc(1);
         chk("stall_tdat", bus.tdat, cw(32'hF3F2F1F0));
         chk("stall_tdatv", 128'(bus.tdatv), 128'hF);
      end
      bus.tready = 1'b1;
      cyc(1);
      chk("resume_1", bus.tdat, cw(32'hF7F6F5F4));
      cyc(1);
      chk("resume_2", bus.tdat, cw(32'hFBFAF9F8));
      cyc(1);
      chk("resume_3", bus.tdat, cw(32'hFFFEFDFC));
      cyc(1);
      chk("cnt_wrap", bus.tdat, cw(32'h03020100));

      // disable mid-DATA, then re-enable
      bus.en = 1'b0;
      cyc(1);
      chk("dis_tdatv", 128'(bus.tdatv), 128'h0);
      cyc(1);
      bus.en = 1'b1;
      cyc(1);
      chk("reen_lat", 128'(bus.tdatv), 128'h0);
      cyc(3);
      cyc(1);
      chk("reen_align4", bus.tdat, COMMA_W);
      chk("reen_align4_k", 128'(bus.tdatk), 128'hFFFF);
      cyc(1);
      chk("reen_cont", bus.tdat, cw(32'h07060504));

      // mid-frame reset, then error injection in counter mode
      rst_n = 1'b0;
      cyc(1);
      chk("mrst_tdatv", 128'(bus.tdatv), 128'h0);
      chk("mrst_errcnt", 128'(bus.err_cnt), 128'h0);
      rst_n = 1'b1;
      cyc(2);
      bus.inject_err = 1'b1;
      cyc(1);
      bus.inject_err = 1'b0;
      chk("inj_align_clean", bus.tdat, COMMA_W);
      chk("inj_align_cnt", 128'(bus.err_cnt), 128'h0);
      cyc(2);
      cyc(1);
      chk("inj_w1", bus.tdat, cw(32'h03020100) ^ 128'h1);
      chk("inj_w1_cnt", 128'(bus.err_cnt), 128'h1);
      bus.inject_err = 1'b1;
      cyc(1);
      bus.inject_err = 1'b0;
      chk("inj_w2", bus.tdat, cw(32'h07060504));
      chk("inj_w2_cnt", 128'(bus.err_cnt), 128'h1);
      cyc(1);
      chk("inj_w3", bus.tdat, cw(32'h0B0A0908) ^ 128'h1);
      chk("inj_w3_cnt", 128'(bus.err_cnt), 128'h2);

      // PRBS-31 mode
      rst_n    = 1'b0;
      bus.mode = 2'd1;
      cyc(1);
      rst_n = 1'b1;
      cyc(5);
      cyc(1);
      chk("prbs_w1", bus.tdat, PRBS_W0);
      bus.inject_err = 1'b1;
      cyc(1);
      bus.inject_err = 1'b0;
      cyc(1);
      chk("prbs_inj_cnt", 128'(bus.err_cnt), 128'h1);
      rst_n = 1'b0;
      cyc(1);
      chk("prbs_rst_tdatv", 128'(bus.tdatv), 128'h0);
      chk("prbs_rst_errcnt", 128'(bus.err_cnt), 128'h0);
      rst_n = 1'b1;
      cyc(5);
      cyc(1);
      chk("prbs_reseed", bus.tdat, PRBS_W0);

      // fixed byte, mode change ignored mid-frame
      rst_n         = 1'b0;
      bus.mode      = 2'd3;
      bus.fixed_pat = 8'hA5;
      cyc(1);
      rst_n = 1'b1;
      cyc(5);
      cyc(1);
      chk("fixed_w1", bus.tdat, {16{8'hA5}});
      bus.mode = 2'd2;
      cyc(1);
      chk("fixed_hold_mode", bus.tdat, {16{8'hA5}});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/lane_pattern_gen.md
Name: lane_pattern_gen

Overview:
- Multi-lane transmit-side stimulus source that produces the per-lane tdat/tdatk/tdatv bus consumed by the lane trace monitor.
- Emits periodic K-comma alignment bursts between data payload. Payload is PRBS-31, an incrementing counter, or a fixed byte.
- Supports single-bit error injection and output backpressure, so link checkers and trace logging can be exercised without a real PHY.

Parameters:
- LANS, 4, number of lanes
- BYTES, 4, bytes per lane per word
- COMMA, 8'hBC, K-character value used in alignment words
- ALIGN_PERIOD, 256, words per frame (alignment plus payload); legal range > ALIGN_LEN
- ALIGN_LEN, 4, alignment words at the start of each frame; legal range ≥ 1

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- en  in  1  generator enable
- mode  in  2  payload select: 0 zero, 1 PRBS-31, 2 counter, 3 fixed
- fixed_pat  in  8  byte used in mode 3
- inject_err  in  1  single-cycle request to corrupt one payload bit
- tready  in  1  downstream accept
- tdat  out  LANS*BYTES*8  lane data; lane l, byte b at bits [(l*BYTES+b)*8 +: 8]
- tdatk  out  LANS*BYTES  per-byte K flag, same ordering
- tdatv  out  LANS  per-lane valid; all bits always equal
- err_cnt  out  16  injected-error count, saturating at 16'hFFFF

Behaviour:
- Reset is synchronous, active-low (rst_n), clock is clk; all state changes occur on posedge clk.
- Reset values: tdat=0, tdatk=0, tdatv=0, err_cnt=0, state=IDLE, word_cnt=0, cnt8=0, err_pend=0, active_mode=0. LFSR of lane l is seeded 31'h1<<l (LANS≤31).
- Advance condition: adv = !tdatv || tready. When adv=0, all outputs and internal state hold.
  - Exception: an inject_err pulse is always captured into err_pend.
- FSM states: IDLE, ALIGN, DATA.
  - IDLE: tdatv=0. When en=1 and adv=1, go to ALIGN, latch active_mode=mode, word_cnt=0. The first alignment word is valid the next cycle (1-cycle latency from en).
  - ALIGN: each accepted word has every byte = COMMA and tdatk all 1, on all lanes. word_cnt increments per accepted word. On the word with word_cnt==ALIGN_LEN-1 being issued, go to DATA.
  - DATA: payload words with tdatk=0. On the word with word_cnt==ALIGN_PERIOD-1, wrap word_cnt to 0, re-latch active_mode=mode, and go to ALIGN.
  - mode changes are ignored mid-frame.
- en=0 in ALIGN or DATA: at the next adv, go to IDLE and tdatv=0. LFSRs and cnt8 keep their values, so re-enable continues the sequence.
- Payload in mode 1, per lane: the LFSR steps BYTES*8 times per word.
  - Each step: n=s[30]^s[27]; s={s[29:0],n}; n is the output bit.
  - Bits fill byte 0 bit 0 first, up to byte BYTES-1 bit 7.
  - The LFSR advances only on payload words.
- Payload in mode 2: byte b = cnt8+b (mod 256), identical on all lanes. cnt8 += BYTES per payload word, wrapping mod 256.
- Payload in mode 3: every byte = fixed_pat. Mode 0: every byte = 0.
- Error injection:
  - inject_err sets err_pend.
  - The next payload word issued inverts bit 0 of lane 0 byte 0. err_pend clears and err_cnt increments (saturating) on that word.
  - Alignment words are never corrupted; pend carries across them.
  - A second pulse while pending is merged (counts once).
- Simultaneous events:
  - Frame wrap together with en=0: IDLE wins.
  - rst_n=0 overrides everything, mid-frame included.

Decomposition:
- Package lane_gen_pkg: state enum {IDLE, ALIGN, DATA}, mode encodings, PRBS31 tap constants, default COMMA.
- Sub-module lane_prbs31: one per lane. Parameters SEED and NBITS. Inputs step and clk/rst_n; output NBITS-bit parallel word. Implemented as an unrolled loop of the step equation.

Test Plan:
- Reset then en=1, mode=2, tready=1, default params:
  - 4 words of 32'hBCBCBCBC with tdatk=4'hF per lane.
  - Then word 5 lane 0 = 32'h03020100 and word 6 = 32'h07060504; tdatk=0.
  - Word 257 (first word of the next frame) is comma again.
- mode=1, lane 0: the first payload word matches a reference PRBS-31 model seeded 31'h1. Lanes 1 to 3 differ from lane 0 and match seeds 2, 4 and 8.
- mode=2 with tready held 0 for 5 cycles mid-DATA: tdat and tdatv are stable during the stall; after release the counter resumes with no skipped or duplicated value.
- inject_err pulsed during ALIGN:
  - The first payload word has lane 0 byte 0 = 8'h01 (mode 2, cnt8=0); all other bytes are correct.
  - err_cnt=1.
  - A second pulse one cycle later gives err_cnt=2 on the following word.
- en dropped mid-DATA then raised:
  - tdatv=0 one cycle after en=0.
  - On re-enable, 4 comma words are followed by a counter continuing from the pre-stop value.
- rst_n=0 for one cycle mid-frame: next cycle tdatv=0, err_cnt=0, and the LFSR is reseeded (sequence restarts identically).
